// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator for the HDMI/DVI output path (pixel clock domain).
//
// Two timelines come out of one pair of raster counters:
//   - request timeline (o_req, o_req_x/y, o_newline, o_newframe): decoded
//     combinationally from the counters, used to prefetch pixels from the
//     frame buffer.
//   - display timeline (o_de, o_hsync, o_vsync, o_x/y): the same information
//     delayed LATENCY cycles so it meets the fetched pixel data at the TMDS
//     encoders.
//
// Ports
//   clk_pixel   pixel clock, the only clock
//   rst         synchronous active-low reset
//   i_run       1 = generate frames; sampled in IDLE and on the last frame cycle
//   o_req       request timeline inside active area
//   o_req_x/y   request coordinates (raw counter values)
//   o_newline   request timeline at last active pixel of any line
//   o_newframe  request timeline at last active pixel of last active line
//   o_de        display enable (o_req delayed LATENCY)
//   o_hsync     horizontal sync at HS_POL, delayed LATENCY
//   o_vsync     vertical sync at VS_POL, delayed LATENCY
//   o_x/y       o_req_x/y delayed LATENCY
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int LATENCY  = 2,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW = $clog2((HT > VT) ? HT : VT)
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic          i_run,
  output logic          o_req,
  output logic [CW-1:0] o_req_x,
  output logic [CW-1:0] o_req_y,
  output logic          o_newline,
  output logic          o_newframe,
  output logic          o_de,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y
);

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_ALAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_SBEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SEND  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST  = CW'(HT - 1);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_ALAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_SBEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SEND  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST  = CW'(VT - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // One display-pipeline stage; the valid (req) bit travels in vld_pipe.
  typedef struct packed {
    logic          hs;
    logic          vs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } disp_t;

  state_t        state;
  logic [CW-1:0] cx, cy;
  logic          h_last, v_last;
  logic          running;
  logic          req_raw, hs_raw, vs_raw;
  disp_t         dsp_in, dsp_d;
  logic          de_d;

  assign h_last = (cx == H_LAST);
  assign v_last = (cy == V_LAST);

  // Counters only move in RUN. Entering RUN leaves them at (0,0) for the
  // first cycle; leaving RUN happens on the wrap edge so they are already 0.
  always_ff @(posedge clk_pixel) begin
    if (!rst) begin
      state <= ST_IDLE;
      cx    <= '0;
      cy    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (i_run) state <= ST_RUN;
        ST_RUN: begin
          if (h_last) begin
            cx <= '0;
            if (v_last) begin
              cy <= '0;
              if (!i_run) state <= ST_IDLE;
            end else begin
              cy <= cy + ONE;
            end
          end else begin
            cx <= cx + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gating by rst makes the decoded pulses drop as soon as reset is
  // asserted, not one edge later.
  assign running = (state == ST_RUN) && rst;
  assign req_raw = running && (cx < H_ACT) && (cy < V_ACT);
  assign hs_raw  = running && (cx >= H_SBEG) && (cx < H_SEND);
  assign vs_raw  = running && (cy >= V_SBEG) && (cy < V_SEND);

  assign o_req      = req_raw;
  assign o_req_x    = cx;
  assign o_req_y    = cy;
  assign o_newline  = running && (cx == H_ALAST);
  assign o_newframe = running && (cx == H_ALAST) && (cy == V_ALAST);

  always_comb begin
    dsp_in    = '0;
    dsp_in.hs = hs_raw;
    dsp_in.vs = vs_raw;
    dsp_in.x  = cx;
    dsp_in.y  = cy;
  end

  // Display delay line. It keeps shifting in IDLE so it drains to the
  // inactive state LATENCY cycles after a stop.
  generate
    if (LATENCY == 0) begin : g_nopipe
      assign de_d  = req_raw;
      assign dsp_d = dsp_in;
    end else begin : g_pipe
      logic [LATENCY:1] vld_pipe;
      disp_t            dsp_pipe [LATENCY:1];

      always_ff @(posedge clk_pixel) begin
        if (!rst) begin
          vld_pipe <= '0;
          for (int i = 1; i <= LATENCY; i++) dsp_pipe[i] <= '0;
        end else begin
          vld_pipe[1] <= req_raw;
          dsp_pipe[1] <= dsp_in;
          for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dsp_pipe[i] <= dsp_pipe[i-1];
          end
        end
      end

      assign de_d  = vld_pipe[LATENCY];
      assign dsp_d = dsp_pipe[LATENCY];
    end
  endgenerate

  // Display outputs forced to their idle values while reset is held, which
  // also covers LATENCY=0 where they would otherwise follow the counters.
  assign o_de    = rst & de_d;
  assign o_hsync = (rst & dsp_d.hs) ? HS_POL : ~HS_POL;
  assign o_vsync = (rst & dsp_d.vs) ? VS_POL : ~VS_POL;
  assign o_x     = rst ? dsp_d.x : '0;
  assign o_y     = rst ? dsp_d.y : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Two instances share one clock:
//   A: default horizontal timing (800 clocks/line), short vertical
//      (8/2/2/3 -> 15 lines), positive syncs, LATENCY=2.
//   B: tiny geometry H 4/1/2/1, V 3/1/1/1, negative syncs, LATENCY=0.
// B is driven from a table of hand-computed vectors; A is covered by
// hand-written sequences (start-up, a frame and a half of monitoring,
// stop at frame end, reset mid-frame).
module tb_video_timing_gen;

  localparam int ACW = 10;
  localparam int BCW = 3;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic           a_rst, a_run, a_req, a_nl, a_nf, a_de, a_hs, a_vs;
  logic [ACW-1:0] a_rx, a_ry, a_x, a_y;
  logic           b_rst, b_run, b_req, b_nl, b_nf, b_de, b_hs, b_vs;
  logic [BCW-1:0] b_rx, b_ry, b_x, b_y;

  video_timing_gen #(
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .LATENCY(2)
  ) dut_a (
    .clk_pixel(clk_pixel), .rst(a_rst), .i_run(a_run),
    .o_req(a_req), .o_req_x(a_rx), .o_req_y(a_ry),
    .o_newline(a_nl), .o_newframe(a_nf),
    .o_de(a_de), .o_hsync(a_hs), .o_vsync(a_vs), .o_x(a_x), .o_y(a_y)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LATENCY(0)
  ) dut_b (
    .clk_pixel(clk_pixel), .rst(b_rst), .i_run(b_run),
    .o_req(b_req), .o_req_x(b_rx), .o_req_y(b_ry),
    .o_newline(b_nl), .o_newframe(b_nf),
    .o_de(b_de), .o_hsync(b_hs), .o_vsync(b_vs), .o_x(b_x), .o_y(b_y)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Inputs, cycles to advance, then expected outputs (hs/vs are pin levels).
  typedef struct {
    logic rst, run;
    int   n;
    int   x, y;
    logic req, de, hs, vs, nl, nf;
  } vec_t;

  vec_t tv [0:22];

  initial begin
    int   found, per, nl_c, rq_c, mis;
    int   ex, ey, cyc;
    logic [ACW-1:0] d1x, d1y, d2x, d2y;
    logic d1q, d2q;
    int   e_cnt, e_req, e_nl, e_nf, e_de, e_xy, e_hs, e_vs;
    int   bad_de, bad_hs, bad_vs, n_de_hi, n_hs_runs, n_vs_runs;
    int   de_run, hs_run, vs_run;
    logic p_de, p_hs, p_vs;
    int   nf_n, nf0, nf1, nl_between;

    //            rst run n   x y  req de hs vs nl nf
    tv[0]  = '{0, 0, 2,  0, 0, 0, 0, 1, 1, 0, 0};
    tv[1]  = '{1, 1, 1,  0, 0, 1, 1, 1, 1, 0, 0};
    tv[2]  = '{1, 1, 3,  3, 0, 1, 1, 1, 1, 1, 0};
    tv[3]  = '{1, 1, 1,  4, 0, 0, 0, 1, 1, 0, 0};
    tv[4]  = '{1, 1, 1,  5, 0, 0, 0, 0, 1, 0, 0};
    tv[5]  = '{1, 1, 1,  6, 0, 0, 0, 0, 1, 0, 0};
    tv[6]  = '{1, 1, 1,  7, 0, 0, 0, 1, 1, 0, 0};
    tv[7]  = '{1, 1, 1,  0, 1, 1, 1, 1, 1, 0, 0};
    tv[8]  = '{1, 1, 11, 3, 2, 1, 1, 1, 1, 1, 1};
    tv[9]  = '{1, 1, 1,  4, 2, 0, 0, 1, 1, 0, 0};
    tv[10] = '{1, 1, 4,  0, 3, 0, 0, 1, 1, 0, 0};
    tv[11] = '{1, 1, 3,  3, 3, 0, 0, 1, 1, 1, 0};
    tv[12] = '{1, 1, 5,  0, 4, 0, 0, 1, 0, 0, 0};
    tv[13] = '{1, 1, 5,  5, 4, 0, 0, 0, 0, 0, 0};
    tv[14] = '{1, 1, 3,  0, 5, 0, 0, 1, 1, 0, 0};
    tv[15] = '{1, 0, 7,  7, 5, 0, 0, 1, 1, 0, 0};  // run dropped, frame finishes
    tv[16] = '{1, 0, 1,  0, 0, 0, 0, 1, 1, 0, 0};  // now IDLE
    tv[17] = '{1, 0, 3,  0, 0, 0, 0, 1, 1, 0, 0};
    tv[18] = '{1, 1, 1,  0, 0, 1, 1, 1, 1, 0, 0};  // restart at (0,0)
    tv[19] = '{1, 1, 1,  1, 0, 1, 1, 1, 1, 0, 0};
    tv[20] = '{1, 0, 10, 3, 1, 1, 1, 1, 1, 1, 0};  // mid-frame stop ignored
    tv[21] = '{0, 0, 1,  0, 0, 0, 0, 1, 1, 0, 0};  // reset aborts frame
    tv[22] = '{1, 1, 1,  0, 0, 1, 1, 1, 1, 0, 0};

    a_rst = 1'b0; a_run = 1'b0;
    b_rst = 1'b0; b_run = 1'b0;
    #1;

    // ---------------- B: table-driven ----------------
    for (int i = 0; i <= 22; i++) begin
      b_rst = tv[i].rst;
      b_run = tv[i].run;
      repeat (tv[i].n) tick();
      check($sformatf("B.v%0d.req_x", i), b_rx, tv[i].x);
      check($sformatf("B.v%0d.req_y", i), b_ry, tv[i].y);
      check($sformatf("B.v%0d.o_x", i), b_x, tv[i].x);
      check($sformatf("B.v%0d.o_y", i), b_y, tv[i].y);
      check($sformatf("B.v%0d.req", i), b_req, tv[i].req);
      check($sformatf("B.v%0d.de", i), b_de, tv[i].de);
      check($sformatf("B.v%0d.hsync", i), b_hs, tv[i].hs);
      check($sformatf("B.v%0d.vsync", i), b_vs, tv[i].vs);
      check($sformatf("B.v%0d.newline", i), b_nl, tv[i].nl);
      check($sformatf("B.v%0d.newframe", i), b_nf, tv[i].nf);
    end

    // B: frame period between newframe pulses
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (b_nf) begin found = 1; break; end
      tick();
    end
    check("B.nf_seen", found, 1);
    tick();
    per = 1; nl_c = 0; rq_c = 0; mis = 0;
    for (int k = 0; k < 200; k++) begin
      if (b_de !== b_req) mis++;
      nl_c += int'(b_nl);
      rq_c += int'(b_req);
      if (b_nf) break;
      tick();
      per++;
    end
    check("B.frame_period", per, 48);
    check("B.newlines_per_frame", nl_c, 6);
    check("B.req_cycles_per_frame", rq_c, 12);
    check("B.de_eq_req", mis, 0);

    // ---------------- A: reset state and start-up ----------------
    check("A.rst.req", a_req, 0);
    check("A.rst.de", a_de, 0);
    check("A.rst.x", a_x, 0);
    check("A.rst.y", a_y, 0);
    check("A.rst.hsync", a_hs, 0);
    check("A.rst.vsync", a_vs, 0);
    check("A.rst.newline", a_nl, 0);

    a_rst = 1'b1; a_run = 1'b1;
    tick();  // E0
    check("A.start.req", a_req, 1);
    check("A.start.req_x", a_rx, 0);
    check("A.start.req_y", a_ry, 0);
    check("A.start.de_e0", a_de, 0);
    d2x = a_rx; d2y = a_ry; d2q = a_req;
    tick();
    check("A.start.de_e1", a_de, 0);
    check("A.start.req_x_e1", a_rx, 1);
    d1x = a_rx; d1y = a_ry; d1q = a_req;
    tick();
    check("A.start.de_e2", a_de, 1);
    check("A.start.o_x_e2", a_x, 0);

    // ---------------- A: monitor ~1.5 frames ----------------
    ex = 2; ey = 0;
    e_cnt = 0; e_req = 0; e_nl = 0; e_nf = 0; e_de = 0; e_xy = 0; e_hs = 0; e_vs = 0;
    bad_de = 0; bad_hs = 0; bad_vs = 0; n_de_hi = 0; n_hs_runs = 0; n_vs_runs = 0;
    de_run = 0; hs_run = 0; vs_run = 0;
    p_de = a_de; p_hs = a_hs; p_vs = a_vs;
    nf_n = 0; nf0 = 0; nf1 = 0; nl_between = 0;
    for (cyc = 0; cyc < 18300; cyc++) begin
      if (a_rx !== ACW'(ex) || a_ry !== ACW'(ey)) e_cnt++;
      if (a_req !== ((ex < 640) && (ey < 8))) e_req++;
      if (a_nl !== (ex == 639)) e_nl++;
      if (a_nf !== ((ex == 639) && (ey == 7))) e_nf++;
      if (a_de !== d2q) e_de++;
      if (a_x !== d2x || a_y !== d2y) e_xy++;
      if (a_hs !== ((d2x >= 656) && (d2x < 752))) e_hs++;
      if (a_vs !== ((d2y >= 10) && (d2y < 12))) e_vs++;

      if (nf_n == 1) nl_between += int'(a_nl);
      if (a_nf) begin
        if (nf_n == 0) nf0 = cyc;
        else if (nf_n == 1) nf1 = cyc;
        nf_n++;
      end

      if (a_de == p_de) de_run++;
      else begin
        if (p_de) begin n_de_hi++; if (de_run != 640) bad_de++; end
        else if (de_run != 160 && de_run != 5760) bad_de++;
        de_run = 1;
      end
      if (a_hs == p_hs) hs_run++;
      else begin
        if (p_hs) begin n_hs_runs++; if (hs_run != 96) bad_hs++; end
        hs_run = 1;
      end
      if (a_vs == p_vs) vs_run++;
      else begin
        if (p_vs) begin n_vs_runs++; if (vs_run != 1600) bad_vs++; end
        vs_run = 1;
      end
      p_de = a_de; p_hs = a_hs; p_vs = a_vs;

      ex++;
      if (ex == 800) begin
        ex = 0; ey++;
        if (ey == 15) ey = 0;
      end
      d2x = d1x; d2y = d1y; d2q = d1q;
      d1x = a_rx; d1y = a_ry; d1q = a_req;
      tick();
    end
    check("A.counters", e_cnt, 0);
    check("A.req_decode", e_req, 0);
    check("A.newline_decode", e_nl, 0);
    check("A.newframe_decode", e_nf, 0);
    check("A.de_delay", e_de, 0);
    check("A.xy_delay", e_xy, 0);
    check("A.hsync_window", e_hs, 0);
    check("A.vsync_window", e_vs, 0);
    check("A.nf_count", nf_n, 2);
    check("A.frame_period", nf1 - nf0, 12000);
    check("A.newlines_per_frame", nl_between, 15);
    check("A.de_run_lengths", bad_de, 0);
    check("A.de_high_runs", n_de_hi, 16);
    check("A.hsync_len", bad_hs, 0);
    check("A.hsync_runs_seen", n_hs_runs >= 20, 1);
    check("A.vsync_len", bad_vs, 0);
    check("A.vsync_runs", n_vs_runs, 1);

    // ---------------- A: stop mid-frame ----------------
    a_run = 1'b0;
    found = 0;
    for (int k = 0; k < 13000; k++) begin
      if (a_rx == 799 && a_ry == 14) begin found = 1; break; end
      tick();
    end
    check("A.stop.reached_frame_end", found, 1);
    tick();
    check("A.stop.idle_req", a_req, 0);
    check("A.stop.idle_x", a_rx, 0);
    check("A.stop.idle_y", a_ry, 0);
    tick();
    check("A.stop.pipe_x", a_x, 799);
    check("A.stop.pipe_y", a_y, 14);
    tick();
    check("A.stop.flush_x", a_x, 0);
    check("A.stop.flush_y", a_y, 0);
    check("A.stop.flush_de", a_de, 0);
    check("A.stop.flush_hsync", a_hs, 0);
    check("A.stop.flush_vsync", a_vs, 0);
    repeat (5) tick();
    check("A.stop.hold_req", a_req, 0);
    check("A.stop.hold_x", a_rx, 0);
    check("A.stop.hold_nl", a_nl, 0);

    a_run = 1'b1;
    tick();
    check("A.restart.req", a_req, 1);
    check("A.restart.req_x", a_rx, 0);
    tick();
    check("A.restart.req_x1", a_rx, 1);
    tick();
    check("A.restart.de", a_de, 1);
    check("A.restart.o_x", a_x, 0);

    // ---------------- A: reset mid-frame ----------------
    found = 0;
    for (int k = 0; k < 13000; k++) begin
      if (a_rx == 300 && a_ry == 5) begin found = 1; break; end
      tick();
    end
    check("A.rstmid.reached", found, 1);
    check("A.rstmid.pre_de", a_de, 1);
    check("A.rstmid.pre_x", a_x, 298);
    check("A.rstmid.pre_y", a_y, 5);
    a_rst = 1'b0;
    tick();
    check("A.rstmid.req", a_req, 0);
    check("A.rstmid.req_x", a_rx, 0);
    check("A.rstmid.req_y", a_ry, 0);
    check("A.rstmid.de", a_de, 0);
    check("A.rstmid.x", a_x, 0);
    check("A.rstmid.y", a_y, 0);
    check("A.rstmid.hsync", a_hs, 0);
    check("A.rstmid.vsync", a_vs, 0);
    tick();
    check("A.rstmid.held_req", a_req, 0);
    a_rst = 1'b1;
    tick();
    check("A.rstrel.req", a_req, 1);
    check("A.rstrel.req_x", a_rx, 0);
    check("A.rstrel.de", a_de, 0);
    tick();
    check("A.rstrel.req_x1", a_rx, 1);
    tick();
    check("A.rstrel.de2", a_de, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
